// File: rtl/mc_cpu_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control unit: opcodes,
// FSM state codes, instruction classes and datapath select codes.
package mc_cpu_pkg;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDI  = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b010000;
  localparam logic [5:0] OP_AND   = 6'b010001;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_SLL   = 6'b011000;
  localparam logic [5:0] OP_SLT   = 6'b100110;
  localparam logic [5:0] OP_SLTIU = 6'b100111;
  localparam logic [5:0] OP_SW    = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_SLTU = 3'b010;
  localparam logic [2:0] ALU_SLT  = 3'b011;
  localparam logic [2:0] ALU_SLL  = 3'b100;
  localparam logic [2:0] ALU_OR   = 3'b101;
  localparam logic [2:0] ALU_AND  = 3'b110;

  localparam logic [1:0] PC_NEXT   = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_RS     = 2'b10;
  localparam logic [1:0] PC_JUMP   = 2'b11;

  localparam logic [1:0] REG_RA = 2'b00;
  localparam logic [1:0] REG_RT = 2'b01;
  localparam logic [1:0] REG_RD = 2'b10;

  localparam logic [1:0] EXT_SA   = 2'b00;
  localparam logic [1:0] EXT_ZERO = 2'b01;
  localparam logic [1:0] EXT_SIGN = 2'b10;

  typedef enum logic [3:0] {
    S_IF     = 4'b0000,
    S_ID     = 4'b0001,
    S_EXE_LS = 4'b0010,
    S_MEM    = 4'b0011,
    S_WB_LD  = 4'b0100,
    S_EXE_BR = 4'b0101,
    S_EXE_AL = 4'b0110,
    S_WB_AL  = 4'b0111,
    S_HALT   = 4'b1000
  } state_t;

  typedef enum logic [3:0] {
    CLS_ALU, CLS_LW, CLS_SW, CLS_BEQ, CLS_J, CLS_JR, CLS_JAL, CLS_HALT, CLS_ILL
  } instr_class_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode decoder: instruction class plus the ALU/operand/extend
// selects that stay stable for the whole life of one instruction.
module mc_decode
  import mc_cpu_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3
) (
  input  logic [OP_W-1:0]    op,
  output instr_class_t       instrClass,
  output logic [ALUOP_W-1:0] aluOp,
  output logic               aluSrcB,
  output logic [1:0]         extSel,
  output logic [1:0]         regOutAlu,
  output logic               legal
);

  always_comb begin
    instrClass = CLS_ALU;
    aluOp      = ALUOP_W'(ALU_ADD);
    aluSrcB    = 1'b0;
    extSel     = EXT_SIGN;
    regOutAlu  = REG_RD;
    legal      = 1'b1;
    case (op)
      OP_ADD:   ;
      OP_SUB:   aluOp = ALUOP_W'(ALU_SUB);
      OP_ADDI:  begin aluSrcB = 1'b1; regOutAlu = REG_RT; end
      OP_OR:    aluOp = ALUOP_W'(ALU_OR);
      OP_AND:   aluOp = ALUOP_W'(ALU_AND);
      OP_ORI:   begin aluOp = ALUOP_W'(ALU_OR); aluSrcB = 1'b1; extSel = EXT_ZERO; regOutAlu = REG_RT; end
      // sll takes its shift amount through the immediate path but writes rd
      OP_SLL:   begin aluOp = ALUOP_W'(ALU_SLL); aluSrcB = 1'b1; extSel = EXT_SA; end
      OP_SLT:   aluOp = ALUOP_W'(ALU_SLT);
      OP_SLTIU: begin aluOp = ALUOP_W'(ALU_SLTU); aluSrcB = 1'b1; regOutAlu = REG_RT; end
      OP_SW:    begin instrClass = CLS_SW; aluSrcB = 1'b1; end
      OP_LW:    begin instrClass = CLS_LW; aluSrcB = 1'b1; end
      OP_BEQ:   begin instrClass = CLS_BEQ; aluOp = ALUOP_W'(ALU_SUB); end
      OP_J:     instrClass = CLS_J;
      OP_JR:    instrClass = CLS_JR;
      OP_JAL:   instrClass = CLS_JAL;
      OP_HALT:  instrClass = CLS_HALT;
      default:  begin instrClass = CLS_ILL; legal = 1'b0; end
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle control FSM (IF/ID/EXE/MEM/WB/HALT) with req/ready memory
// handshakes. Define MC_PERF_CNT_EN to build the cycle/instruction counters.
module mc_control_fsm
  import mc_cpu_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3,
  parameter int CNT_W   = 32
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [OP_W-1:0]    op,
  input  logic               zero,
  input  logic               imem_ready,
  input  logic               dmem_ready,
  output logic               imem_req,
  output logic               dmem_req,
  output logic               PCWre,
  output logic               ALUSrcB,
  output logic               ALUM2Reg,
  output logic               RegWre,
  output logic               WrRegData,
  output logic               InsMemRW,
  output logic               DataMemRW,
  output logic               IRWre,
  output logic [1:0]         ExtSel,
  output logic [1:0]         PCSrc,
  output logic [1:0]         RegOut,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [3:0]         state,
  output logic               halted,
  output logic               illegal_op,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [CNT_W-1:0]   instr_cnt
);

  // Handshake: imem_req/dmem_req are level requests held for the whole of
  // IF/MEM; an access completes in the cycle its ready is sampled high, and a
  // ready seen in any state that is not requesting it is ignored.

  state_t             curState, nextState;
  instr_class_t       decClass;
  logic [ALUOP_W-1:0] decAluOp;
  logic               decSrcB, decLegal;
  logic [1:0]         decExt, decRegOut;

  mc_decode #(.OP_W(OP_W), .ALUOP_W(ALUOP_W)) u_decode (
    .op         (op),
    .instrClass (decClass),
    .aluOp      (decAluOp),
    .aluSrcB    (decSrcB),
    .extSel     (decExt),
    .regOutAlu  (decRegOut),
    .legal      (decLegal)
  );

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) curState <= S_IF;
    else       curState <= nextState;
  end

  always_comb begin
    nextState  = curState;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    PCWre      = 1'b0;
    ALUSrcB    = 1'b0;
    ALUM2Reg   = 1'b0;
    RegWre     = 1'b0;
    WrRegData  = 1'b1;
    DataMemRW  = 1'b0;
    IRWre      = 1'b0;
    ExtSel     = EXT_SIGN;
    PCSrc      = PC_NEXT;
    RegOut     = REG_RT;
    ALUOp      = ALUOP_W'(ALU_ADD);
    illegal_op = 1'b0;
    // The IR is stable from ID onward, so decoded selects are held to the end
    if (curState != S_IF && curState != S_HALT) begin
      ALUOp   = decAluOp;
      ALUSrcB = decSrcB;
      ExtSel  = decExt;
    end
    case (curState)
      S_IF: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          IRWre     = 1'b1;
          nextState = S_ID;
        end
      end
      S_ID: begin
        if (!decLegal) begin
          illegal_op = 1'b1;
          PCWre      = 1'b1;
          nextState  = S_IF;
        end else begin
          case (decClass)
            CLS_J:    begin PCSrc = PC_JUMP; PCWre = 1'b1; nextState = S_IF; end
            CLS_JR:   begin PCSrc = PC_RS;   PCWre = 1'b1; nextState = S_IF; end
            CLS_JAL: begin
              PCSrc     = PC_JUMP;
              PCWre     = 1'b1;
              RegWre    = 1'b1;
              RegOut    = REG_RA;
              WrRegData = 1'b0;
              nextState = S_IF;
            end
            CLS_HALT:      nextState = S_HALT;
            CLS_BEQ:       nextState = S_EXE_BR;
            CLS_LW, CLS_SW: nextState = S_EXE_LS;
            default:       nextState = S_EXE_AL;
          endcase
        end
      end
      S_EXE_AL: nextState = S_WB_AL;
      S_WB_AL: begin
        RegWre    = 1'b1;
        RegOut    = decRegOut;
        PCWre     = 1'b1;
        nextState = S_IF;
      end
      S_EXE_BR: begin
        PCWre     = 1'b1;
        PCSrc     = zero ? PC_BRANCH : PC_NEXT;
        nextState = S_IF;
      end
      S_EXE_LS: nextState = S_MEM;
      S_MEM: begin
        dmem_req  = 1'b1;
        DataMemRW = (decClass == CLS_SW);
        if (dmem_ready) begin
          if (decClass == CLS_SW) begin
            PCWre     = 1'b1;
            nextState = S_IF;
          end else begin
            nextState = S_WB_LD;
          end
        end
      end
      S_WB_LD: begin
        RegWre    = 1'b1;
        ALUM2Reg  = 1'b1;
        RegOut    = REG_RT;
        PCWre     = 1'b1;
        nextState = S_IF;
      end
      S_HALT:  nextState = S_HALT;
      default: nextState = S_IF;
    endcase
    // Enables and the data request must not leak out while Reset is held
    if (Reset) begin
      IRWre      = 1'b0;
      PCWre      = 1'b0;
      RegWre     = 1'b0;
      DataMemRW  = 1'b0;
      dmem_req   = 1'b0;
      illegal_op = 1'b0;
    end
  end

  assign state    = curState;
  assign halted   = (curState == S_HALT);
  assign InsMemRW = 1'b0;

`ifdef MC_PERF_CNT_EN
  logic [CNT_W-1:0] cycleCnt, instrCnt;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      cycleCnt <= '0;
      instrCnt <= '0;
    end else begin
      if (curState != S_HALT) cycleCnt <= cycleCnt + CNT_W'(1);
      if (PCWre)              instrCnt <= instrCnt + CNT_W'(1);
    end
  end

  assign cycle_cnt = cycleCnt;
  assign instr_cnt = instrCnt;
`else
  assign cycle_cnt = '0;
  assign instr_cnt = '0;
`endif

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Next-generation multi-cycle MIPS-subset control unit: a Moore/Mealy FSM sequencing IF/ID/EXE/MEM/WB and driving the existing datapath select/enable signals.
- Memory handshakes (req/ready) replace fixed single-cycle memory, so instruction and data memories may insert wait states.
- Adds a HALT state, illegal-opcode trap and optional performance counters.
- Sits beside the PC, register file, ALU and pipeline latches inside the CPU top level.

Parameters:
- OP_W, 6, opcode width
- ALUOP_W, 3, ALU operation code width
- CNT_W, 32, width of performance counters

Ports:
- CLK  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- op  in  OP_W  opcode from instruction register
- zero  in  1  ALU zero flag
- imem_ready  in  1  instruction memory data valid
- dmem_ready  in  1  data memory access complete
- imem_req  out  1  instruction fetch request
- dmem_req  out  1  data memory request
- PCWre  out  1  PC update pulse
- ALUSrcB  out  1  ALU B operand: 0 = register, 1 = extended immediate
- ALUM2Reg  out  1  writeback data: 0 = ALU, 1 = memory
- RegWre  out  1  register-file write enable
- WrRegData  out  1  0 = PC+4 (jal), 1 = ALU/memory
- InsMemRW  out  1  constant 0
- DataMemRW  out  1  1 = write (sw)
- IRWre  out  1  instruction register load
- ExtSel  out  2  00 = sa zero-extend, 01 = imm zero-extend, 10 = sign-extend
- PCSrc  out  2  00 = PC+4, 01 = branch, 10 = rs (jr), 11 = jump target
- RegOut  out  2  00 = $31, 01 = rt, 10 = rd
- ALUOp  out  ALUOP_W  operation code
- state  out  4  current state, for debug
- halted  out  1  high while in HALT
- illegal_op  out  1  one-cycle pulse on an undefined opcode
- cycle_cnt  out  CNT_W  cycles since reset
- instr_cnt  out  CNT_W  retired instructions

Behaviour:
- Opcodes: add 000000, sub 000001, addi 000010, or 010000, and 010001, ori 010010, sll 011000, slt 100110, sltiu 100111, sw 110000, lw 110001, beq 110100, j 111000, jr 111001, jal 111010, halt 111111.
- ALUOp encoding: add 000, sub 001, sltu 010, slt 011, sll 100, or 101, and 110.
- States: IF 0000, ID 0001, EXE_LS 0010, MEM 0011, WB_LD 0100, EXE_BR 0101, EXE_AL 0110, WB_AL 0111, HALT 1000.
- Reset: state = IF, counters 0, halted 0. All enables/requests (PCWre, RegWre, IRWre, DataMemRW, dmem_req) are 0 in reset; selects take their IF values.
  - imem_req is combinational from state, so it is asserted while Reset is held and in the first cycle after release.
  - Reset mid-access drops all requests immediately.
- IF: imem_req = 1; hold until imem_ready. In the ready cycle, IRWre = 1, then go to ID.
- ID:
  - j: PCSrc = 11, PCWre = 1, go to IF.
  - jr: PCSrc = 10, PCWre = 1, go to IF.
  - jal: PCSrc = 11, PCWre = 1, RegWre = 1, RegOut = 00, WrRegData = 0, go to IF.
  - halt: go to HALT.
  - beq: go to EXE_BR.
  - lw/sw: go to EXE_LS.
  - ALU ops: go to EXE_AL.
  - Undefined op: illegal_op = 1, PCWre = 1, PCSrc = 00, go to IF (treated as nop).
- EXE_AL: go to WB_AL.
- WB_AL: RegWre = 1, WrRegData = 1, ALUM2Reg = 0; RegOut = 10 for R-type, 01 for immediate ops; PCWre = 1, PCSrc = 00; go to IF.
- EXE_BR: ALUOp = 001; PCWre = 1; PCSrc = 01 if zero else 00; go to IF.
- EXE_LS: ALUOp = 000, ALUSrcB = 1, ExtSel = 10; go to MEM.
- MEM: dmem_req = 1; DataMemRW = 1 for sw; hold until dmem_ready.
  - sw: PCWre = 1 in the ready cycle, go to IF.
  - lw: go to WB_LD.
- WB_LD: RegWre = 1, ALUM2Reg = 1, RegOut = 01, WrRegData = 1, PCWre = 1; go to IF.
- Operand selection: ALUSrcB = 1 for addi, ori, sltiu, sll, lw, sw.
- Extension: ExtSel = 00 for sll, 01 for ori, 10 otherwise.
- ALUOp, ALUSrcB and ExtSel are held from ID through the last state of the instruction.
- PCWre is exactly a one-cycle pulse in each instruction's final state. RegWre is never high outside WB_AL, WB_LD, or ID for jal.
- HALT: absorbing; all enables 0, halted = 1; exit only via Reset.
- Latency with zero wait states: j/jr/jal/illegal 2 cycles, beq 3, ALU 4, sw 4, lw 5. Each memory wait cycle adds 1.
- Simultaneous events: a ready signal in a non-requesting state is ignored.

Optional Feature:
- Macro MC_PERF_CNT_EN.
- Defined: cycle_cnt increments every cycle except in HALT. instr_cnt increments on each PCWre pulse. Both wrap modulo 2^CNT_W.
- Undefined: both counters are tied to 0 and no counter flops are synthesised.

Decomposition:
- Package mc_cpu_pkg holds the opcode constants, the state encoding, and the ALUOp, PCSrc, RegOut and ExtSel encodings.
- One sub-module, mc_decode: combinational op to {class, ALUOp, ALUSrcB, ExtSel, RegOut_alu, legal}.

Test Plan:
- Reset asserted mid-MEM of lw -> dmem_req drops in the same cycle, state = 0000, RegWre = 0, counters = 0.
- add with imem_ready held 1 -> IF, ID, EXE_AL, WB_AL; RegWre = 1 and RegOut = 10 only in cycle 4; PCWre pulse in cycle 4.
- lw with imem_ready delayed 2 cycles and dmem_ready delayed 3 cycles -> 10 cycles total; IRWre only in the imem_ready cycle; ALUM2Reg = 1 in WB_LD.
- beq with zero = 1, then with zero = 0 -> PCSrc = 01, then 00, in EXE_BR; PCWre asserted both times.
- jal, then opcode 101010 -> first: RegOut = 00, WrRegData = 0, PCSrc = 11 in ID. Second: illegal_op pulse, PCSrc = 00, instr_cnt = 2 (MC_PERF_CNT_EN defined).
- halt -> state = 1000, halted = 1; cycle_cnt frozen; imem_ready pulses ignored; only Reset returns state to IF.
